// File: rtl/datapath_sequencer_pkg.sv
// Shared constants for the datapath sequencer: instruction field layout,
// opcode/op encodings, FSM state encoding and the imm8 sign-extension helper.
package seq_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  // Instruction field bit positions
  localparam int OPC_LO = 13;
  localparam int OP_LO  = 11;
  localparam int RN_LO  = 8;
  localparam int RD_LO  = 5;
  localparam int SH_LO  = 3;
  localparam int RM_LO  = 0;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITEBACK = 3'd6
  } state_t;

  function automatic logic [15:0] sext8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_sequencer_decoder.sv
// Purely combinational instruction decoder: splits the IR into its fields,
// sign-extends imm8 and classifies the instruction for the sequencer FSM.
module instr_decoder
  import seq_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm8,
  output logic        legal,
  output logic        is_mov_imm,
  output logic        is_mov_reg,
  output logic        is_mvn,
  output logic        is_cmp
);

  logic [2:0] opcode;
  logic       is_alu;

  // Field extraction and instruction classification
  always_comb begin
    opcode     = ir[OPC_LO +: 3];
    op         = ir[OP_LO  +: 2];
    rn         = ir[RN_LO  +: 3];
    rd         = ir[RD_LO  +: 3];
    sh         = ir[SH_LO  +: 2];
    rm         = ir[RM_LO  +: 3];
    sximm8     = sext8(ir[7:0]);

    is_alu     = (opcode == OPC_ALU);
    is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    is_mvn     = is_alu && (op == OP_MVN);
    is_cmp     = is_alu && (op == OP_CMP);
    // Every op under the ALU opcode is supported; MOV only has two forms.
    legal      = is_mov_imm || is_mov_reg || is_alu;
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the 8x16 regfile/shifter/ALU datapath.
// Holds one instruction in IR and walks the datapath through read, execute
// and writeback steps; all strobes are Moore outputs of state + IR.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          vsel,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic          loadc,
  output logic          loads,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8,
  output logic          illegal
);

  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;

  logic [1:0]  dec_op;
  logic [2:0]  dec_rn, dec_rd, dec_rm;
  logic [1:0]  dec_sh;
  logic [15:0] dec_sximm8;
  logic        dec_legal, dec_mov_imm, dec_mov_reg, dec_mvn, dec_cmp;

  instr_decoder u_dec (
    .ir         (ir_q),
    .op         (dec_op),
    .rn         (dec_rn),
    .rd         (dec_rd),
    .rm         (dec_rm),
    .sh         (dec_sh),
    .sximm8     (dec_sximm8),
    .legal      (dec_legal),
    .is_mov_imm (dec_mov_imm),
    .is_mov_reg (dec_mov_reg),
    .is_mvn     (dec_mvn),
    .is_cmp     (dec_cmp)
  );

  assign sximm8 = dec_sximm8;

  // IR only accepts a new word while idle so a running instruction is stable.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && load) ir_d = in;
  end

  // State and instruction registers; reset forces an idle, zeroed IR at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and Moore strobe decode from state and IR fields.
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    illegal  = 1'b0;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end

      S_DECODE: begin
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = S_WAIT;
        end else if (dec_mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (dec_mov_reg || dec_mvn) begin
          // Single-operand forms skip the A read; A is forced to zero in EXEC.
          state_d = S_GET_B;
        end else begin
          state_d = S_GET_A;
        end
      end

      S_WRITE_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = dec_rn;
        state_d  = S_WAIT;
      end

      S_GET_A: begin
        readnum = dec_rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end

      S_GET_B: begin
        readnum = dec_rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        shift = dec_sh;
        ALUop = dec_mov_reg ? OP_ADD : dec_op;
        asel  = dec_mov_reg || dec_mvn;
        if (dec_cmp) begin
          // Compare only updates flags; the C register and regfile are untouched.
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        write    = 1'b1;
        writenum = dec_rd;
        state_d  = S_WAIT;
      end

      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a directed vector table, hand-written reset
// sequences, and randomized traffic checked against a schedule-queue model.
module tb_datapath_sequencer;

  logic        clk, reset;
  logic [15:0] in;
  logic        load, s;
  logic        w, write, vsel, loada, loadb, asel, bsel, loadc, loads, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8;

  datapath_sequencer dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic        load;
    logic        s;
    logic [15:0] in;
    outs_t       exp;
    logic [15:0] exp_imm;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Expected-output constructors for each micro-step of an instruction
  function automatic outs_t f_zero();
    outs_t o;
    o = '0;
    return o;
  endfunction
  function automatic outs_t f_wait();
    outs_t o = f_zero();
    o.w = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_dec(input logic ill);
    outs_t o = f_zero();
    o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t f_wimm(input logic [2:0] rn);
    outs_t o = f_zero();
    o.write = 1'b1; o.vsel = 1'b1; o.writenum = rn;
    return o;
  endfunction
  function automatic outs_t f_geta(input logic [2:0] rn);
    outs_t o = f_zero();
    o.loada = 1'b1; o.readnum = rn;
    return o;
  endfunction
  function automatic outs_t f_getb(input logic [2:0] rm);
    outs_t o = f_zero();
    o.loadb = 1'b1; o.readnum = rm;
    return o;
  endfunction
  function automatic outs_t f_exec(input logic [1:0] sh, input logic [1:0] alu,
                                   input logic a0, input logic flags_only);
    outs_t o = f_zero();
    o.shift = sh; o.aluop = alu; o.asel = a0;
    if (flags_only) o.loads = 1'b1; else o.loadc = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_wb(input logic [2:0] rd);
    outs_t o = f_zero();
    o.write = 1'b1; o.writenum = rd;
    return o;
  endfunction

  function automatic outs_t get_act();
    outs_t o;
    o = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
         loadc, loads, shift, ALUop, illegal};
    return o;
  endfunction

  task automatic chk_o(input string name, input outs_t e);
    outs_t a;
    a = get_act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s outputs got %h want %h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic chk_imm(input string name, input logic [15:0] e);
    checks++;
    if (sximm8 !== e) begin
      errors++;
      $display("FAIL %s sximm8 got %h want %h (t=%0t)", name, sximm8, e, $time);
    end
  endtask

  // Reference model: an instruction is expanded into its list of per-cycle
  // outputs when started; each subsequent edge consumes one entry.
  outs_t       sched[$];
  logic [15:0] m_ir;

  function automatic void expand(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
    if (opc == 3'b110 && op == 2'b10) begin
      sched.push_back(f_dec(1'b0));
      sched.push_back(f_wimm(rn));
    end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
      sched.push_back(f_dec(1'b0));
      sched.push_back(f_getb(rm));
      sched.push_back(f_exec(sh, (opc == 3'b110) ? 2'b00 : op, 1'b1, 1'b0));
      sched.push_back(f_wb(rd));
    end else if (opc == 3'b101) begin
      sched.push_back(f_dec(1'b0));
      sched.push_back(f_geta(rn));
      sched.push_back(f_getb(rm));
      sched.push_back(f_exec(sh, op, 1'b0, op == 2'b01));
      if (op != 2'b01) sched.push_back(f_wb(rd));
    end else begin
      sched.push_back(f_dec(1'b1));
    end
  endfunction

  function automatic void model_edge(input logic l, input logic ss, input logic [15:0] d);
    if (sched.size() == 0) begin
      if (l) m_ir = d;
      if (ss) expand(m_ir);
    end else begin
      void'(sched.pop_front());
    end
  endfunction

  function automatic outs_t model_exp();
    if (sched.size() != 0) return sched[0];
    return f_wait();
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    logic [2:0]  k;
    r = 16'($urandom);
    k = 3'($urandom_range(0, 7));
    case (k)
      3'd0: r[15:11] = 5'b110_10;
      3'd1: r[15:11] = 5'b110_00;
      3'd2: r[15:11] = 5'b101_00;
      3'd3: r[15:11] = 5'b101_01;
      3'd4: r[15:11] = 5'b101_10;
      3'd5: r[15:11] = 5'b101_11;
      default: ;
    endcase
    return r;
  endfunction

  task automatic step(input logic l, input logic ss, input logic [15:0] d);
    @(negedge clk);
    load = l; s = ss; in = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  task automatic add_vec(input logic l, input logic ss, input logic [15:0] d,
                         input outs_t e, input logic [15:0] imm);
    vec_t v;
    v.load = l; v.s = ss; v.in = d; v.exp = e; v.exp_imm = imm;
    vecs.push_back(v);
  endtask

  initial begin
    // MOV R2,#42: load, then start separately
    add_vec(1, 0, 16'hD22A, f_wait(),     16'h002A);
    add_vec(0, 1, 16'h0000, f_dec(0),     16'h002A);
    add_vec(0, 0, 16'h0000, f_wimm(3'd2), 16'h002A);
    add_vec(0, 0, 16'h0000, f_wait(),     16'h002A);
    // MOV R5,#-1 with load and s together
    add_vec(1, 1, 16'hD5FF, f_dec(0),     16'hFFFF);
    add_vec(0, 0, 16'h0000, f_wimm(3'd5), 16'hFFFF);
    add_vec(0, 0, 16'h0000, f_wait(),     16'hFFFF);
    // ADD R7,R2,R5 sh=10; load/s hammered while busy must be ignored
    add_vec(1, 1, 16'hA2F5, f_dec(0),                          16'hFFF5);
    add_vec(1, 1, 16'h0000, f_geta(3'd2),                      16'hFFF5);
    add_vec(1, 1, 16'hD5FF, f_getb(3'd5),                      16'hFFF5);
    add_vec(1, 1, 16'h0000, f_exec(2'b10, 2'b00, 1'b0, 1'b0),  16'hFFF5);
    add_vec(1, 1, 16'h0000, f_wb(3'd7),                        16'hFFF5);
    add_vec(0, 0, 16'h0000, f_wait(),                          16'hFFF5);
    // CMP R2,R5: flags only, 5 edges
    add_vec(1, 1, 16'hAA05, f_dec(0),                          16'h0005);
    add_vec(0, 0, 16'h0000, f_geta(3'd2),                      16'h0005);
    add_vec(0, 0, 16'h0000, f_getb(3'd5),                      16'h0005);
    add_vec(0, 0, 16'h0000, f_exec(2'b00, 2'b01, 1'b0, 1'b1),  16'h0005);
    add_vec(0, 0, 16'h0000, f_wait(),                          16'h0005);
    // MVN R3, R4 sh=01
    add_vec(1, 1, 16'hB86C, f_dec(0),                          16'h006C);
    add_vec(0, 0, 16'h0000, f_getb(3'd4),                      16'h006C);
    add_vec(0, 0, 16'h0000, f_exec(2'b01, 2'b11, 1'b1, 1'b0),  16'h006C);
    add_vec(0, 0, 16'h0000, f_wb(3'd3),                        16'h006C);
    add_vec(0, 0, 16'h0000, f_wait(),                          16'h006C);
    // MOV R1, R6 sh=11
    add_vec(1, 1, 16'hC03E, f_dec(0),                          16'h003E);
    add_vec(0, 0, 16'h0000, f_getb(3'd6),                      16'h003E);
    add_vec(0, 0, 16'h0000, f_exec(2'b11, 2'b00, 1'b1, 1'b0),  16'h003E);
    add_vec(0, 0, 16'h0000, f_wb(3'd1),                        16'h003E);
    add_vec(0, 0, 16'h0000, f_wait(),                          16'h003E);
    // Illegal opcode 111 and illegal MOV op 01
    add_vec(1, 1, 16'hE080, f_dec(1),     16'hFF80);
    add_vec(0, 0, 16'h0000, f_wait(),     16'hFF80);
    add_vec(1, 1, 16'hC801, f_dec(1),     16'h0001);
    add_vec(0, 0, 16'h0000, f_wait(),     16'h0001);

    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0;
    #12;
    chk_o("reset_state", f_wait());
    chk_imm("reset_imm", 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].s, vecs[i].in);
      chk_o($sformatf("vec%0d", i), vecs[i].exp);
      chk_imm($sformatf("vec%0d", i), vecs[i].exp_imm);
    end

    // Asynchronous reset in the middle of an ADD's EXEC cycle
    step(1, 1, 16'hA2F5);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    chk_o("add_exec_before_reset", f_exec(2'b10, 2'b00, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk_o("async_reset_outputs", f_wait());
    chk_imm("async_reset_imm", 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 16'h0000);
    chk_o("post_reset_illegal", f_dec(1'b1));
    step(0, 0, 16'h0000);
    chk_o("post_reset_wait", f_wait());

    // Randomized traffic against the model, starting from IR=0 in WAIT
    m_ir = 16'h0;
    sched.delete();
    for (int n = 0; n < 2000; n++) begin
      logic        rl, rs;
      logic [15:0] rd;
      rl = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 2) == 0);
      rd = rand_instr();
      step(rl, rs, rd);
      model_edge(rl, rs, rd);
      chk_o($sformatf("rand%0d", n), model_exp());
      chk_imm($sformatf("rand%0d", n), {{8{m_ir[7]}}, m_ir[7:0]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
